mem_access_ctrl: RTL and testbench

Sequencing controller between the datapath's MAR/MDR and the byte-wide 256×8 RAM. It accepts one word, halfword or byte transfer from the control unit (MOV, R/W, size mode), splits it into big-endian byte beats with programmable wait states, and assembles read data with zero or sign extension. It returns MOC to the control unit when the transfer is complete.

---
 rtl/mem_if_pkg.sv | 28 ++
 rtl/mem_read_assembler.sv | 38 +++
 rtl/mem_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the MAR/MDR-to-byte-RAM sequencer.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Number of byte beats for a size code; the reserved code behaves as a word.
  function automatic logic [2:0] beats_for_size(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Byte lane sel of a 32-bit word, lane 0 being the least significant byte.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_read_assembler.sv
// Collects read bytes most-significant first and extends them to 32 bits.
module mem_read_assembler
  import mem_if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  rdata,
  input  logic [2:0]  nbeats,
  input  logic        sext,
  output logic [31:0] data
);

  logic [31:0] asm_q;

  // Shift register: cleared at request acceptance, one byte in per read beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
    end else if (clear) begin
      asm_q <= '0;
    end else if (shift) begin
      asm_q <= {asm_q[23:0], rdata};
    end
  end

  // Zero/sign extension from the top bit of the assembled width.
  always_comb begin
    data = asm_q;
    case (nbeats)
      3'd1:    data = {{24{sext & asm_q[7]}},  asm_q[7:0]};
      3'd2:    data = {{16{sext & asm_q[15]}}, asm_q[15:0]};
      default: data = asm_q;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Splits word/halfword/byte transfers into big-endian byte beats with
// programmable wait states and returns MOC when the transfer is complete.
//
// state | meaning
// IDLE  | waiting for MOV; RAM strobes low
// BEAT  | driving byte beat k for WAIT_CYCLES+1 cycles
// DONE  | first cycle raises MOC, then hold MOC until MOV drops
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BITS   = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 MOV,
  input  logic                 RW,
  input  logic [2:0]           MS,
  input  logic [31:0]          ADDR,
  input  logic [31:0]          DATA_IN,
  output logic                 MOC,
  output logic                 ALIGN_ERR,
  output logic [31:0]          DATA_OUT,
  output logic                 MEM_EN,
  output logic                 MEM_WE,
  output logic [ADDR_BITS-1:0] MEM_ADDR,
  output logic [7:0]           MEM_WDATA,
  input  logic [7:0]           MEM_RDATA
);

  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

  state_t         state, state_nxt;
  logic [2:0]     wait_cnt;
  logic [1:0]     beat_idx;
  logic [1:0]     last_idx;
  logic [2:0]     nbeats;
  logic [31:0]    wdata_q;
  logic           rw_q;
  logic           sext_q;

  logic           accept, beat_end, last_beat, done_set, done_clr;
  logic [2:0]     req_beats;
  logic [ADDR_BITS-1:0] req_base;
  logic           req_misalign;
  logic [31:0]    asm_data;

  // Upper MAR bits do not reach the 256-byte RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDR[31:ADDR_BITS];

  assign last_idx = 2'(nbeats - 3'd1);

  // Request decode: beat count, aligned base address and misalignment flag.
  always_comb begin
    req_beats    = beats_for_size(MS[1:0]);
    req_base     = ADDR[ADDR_BITS-1:0];
    req_misalign = 1'b0;
    if (req_beats == 3'd4) begin
      req_misalign = |ADDR[1:0];
      req_base[1:0] = 2'b00;
    end else if (req_beats == 3'd2) begin
      req_misalign = ADDR[0];
      req_base[0]  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    beat_end  = 1'b0;
    last_beat = 1'b0;
    done_set  = 1'b0;
    done_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (MOV) begin
          accept    = 1'b1;
          state_nxt = BEAT;
        end
      end
      BEAT: begin
        if (wait_cnt == 3'd0) begin
          beat_end = 1'b1;
          if (beat_idx == last_idx) begin
            last_beat = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // MOC is raised unconditionally so a dropped MOV still sees one pulse.
        if (!MOC) begin
          done_set = 1'b1;
        end else if (!MOV) begin
          done_clr  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, beat/wait counters and registered RAM-side outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt  <= '0;
      beat_idx  <= '0;
      nbeats    <= 3'd1;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      sext_q    <= 1'b0;
      ALIGN_ERR <= 1'b0;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else if (accept) begin
      wait_cnt  <= WAIT_LD;
      beat_idx  <= '0;
      nbeats    <= req_beats;
      wdata_q   <= DATA_IN;
      rw_q      <= RW;
      sext_q    <= MS[2];
      ALIGN_ERR <= req_misalign;
      MEM_EN    <= 1'b1;
      MEM_WE    <= ~RW;
      MEM_ADDR  <= req_base;
      MEM_WDATA <= pick_byte(DATA_IN, 2'(req_beats - 3'd1));
    end else if (beat_end) begin
      wait_cnt <= WAIT_LD;
      if (last_beat) begin
        beat_idx <= '0;
        MEM_EN   <= 1'b0;
        MEM_WE   <= 1'b0;
      end else begin
        beat_idx  <= beat_idx + 2'd1;
        MEM_ADDR  <= MEM_ADDR + ADDR_BITS'(1);
        MEM_WDATA <= pick_byte(wdata_q, 2'(nbeats - 3'd2 - {1'b0, beat_idx}));
      end
    end else if (state == BEAT) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Completion handshake and read-data capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MOC      <= 1'b0;
      DATA_OUT <= '0;
    end else if (done_set) begin
      MOC <= 1'b1;
      if (rw_q) DATA_OUT <= asm_data;
    end else if (done_clr) begin
      MOC <= 1'b0;
    end
  end

  mem_read_assembler u_asm (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clear  (accept),
    .shift  (beat_end & rw_q),
    .rdata  (MEM_RDATA),
    .nbeats (nbeats),
    .sext   (sext_q),
    .data   (asm_data)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-wide RAM model.
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        MOV = 1'b0;
  logic        RW = 1'b0;
  logic [2:0]  MS = 3'b000;
  logic [31:0] ADDR = '0;
  logic [31:0] DATA_IN = '0;
  logic        MOC;
  logic        ALIGN_ERR;
  logic [31:0] DATA_OUT;
  logic        MEM_EN;
  logic        MEM_WE;
  logic [7:0]  MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;

  logic [7:0]  ram [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [7:0]  pre_data = '0;

  int n_chk = 0;
  int n_err = 0;
  int lat;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.WAIT_CYCLES(1), .ADDR_BITS(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .MOV       (MOV),
    .RW        (RW),
    .MS        (MS),
    .ADDR      (ADDR),
    .DATA_IN   (DATA_IN),
    .MOC       (MOC),
    .ALIGN_ERR (ALIGN_ERR),
    .DATA_OUT  (DATA_OUT),
    .MEM_EN    (MEM_EN),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA)
  );

  // RAM model: synchronous write, asynchronous read; bench preload port.
  always @(posedge CLK) begin
    if (MEM_EN && MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
    else if (pre_we)      ram[pre_addr] <= pre_data;
  end
  assign MEM_RDATA = ram[MEM_ADDR];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  task automatic start_req(input logic rw, input logic [2:0] ms,
                           input logic [31:0] addr, input logic [31:0] din);
    @(negedge CLK);
    MOV = 1'b1; RW = rw; MS = ms; ADDR = addr; DATA_IN = din;
  endtask

  // Returns edges from acceptance until MOC is seen; optional MOV drop / input scramble.
  task automatic wait_moc(input int drop_at, input bit scramble, output int l);
    l = 0;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      if (MOC) break;
      if (l >= 40) begin
        check("moc_timeout", 32'd0, 32'd1);
        break;
      end
      if (l == drop_at) MOV = 1'b0;
      if (scramble && l == 1) begin
        ADDR = 32'hFF; DATA_IN = '0; MS = 3'b000; RW = 1'b0;
      end
      @(posedge CLK);
      l++;
    end
  endtask

  task automatic release_mov;
    @(negedge CLK);
    MOV = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("moc_drop", {31'd0, MOC}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 RST_N = 1'b0;
    #3;
    check("rst_moc",   {31'd0, MOC},       32'd0);
    check("rst_align", {31'd0, ALIGN_ERR}, 32'd0);
    check("rst_dout",  DATA_OUT,           32'd0);
    check("rst_en",    {31'd0, MEM_EN},    32'd0);
    check("rst_we",    {31'd0, MEM_WE},    32'd0);
    check("rst_addr",  {24'd0, MEM_ADDR},  32'd0);
    check("rst_wdata", {24'd0, MEM_WDATA}, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;

    poke(8'h10, 8'hE0); poke(8'h11, 8'h9C); poke(8'h12, 8'h80); poke(8'h13, 8'h2C);
    poke(8'h22, 8'h80);
    poke(8'h40, 8'h00); poke(8'h41, 8'h00); poke(8'h42, 8'h77);
    for (int i = 0; i < 4; i++) poke(8'(8'h60 + i), 8'h11);
    poke(8'hFF, 8'h5A);

    // Word read, signed; request inputs are scrambled mid-transfer.
    start_req(1'b1, 3'b110, 32'h0000_0010, 32'h0);
    wait_moc(-1, 1'b1, lat);
    check("wr_lat",   lat,                 32'd9);
    check("wr_data",  DATA_OUT,            32'hE09C802C);
    check("wr_align", {31'd0, ALIGN_ERR},  32'd0);
    check("wr_ram_ff", {24'd0, ram[8'hFF]}, 32'h5A);
    release_mov();

    // Halfword reads, signed and unsigned.
    start_req(1'b1, 3'b101, 32'h0000_0010, 32'h0);
    wait_moc(-1, 1'b0, lat);
    check("hr_lat",  lat,      32'd5);
    check("hr_sext", DATA_OUT, 32'hFFFFE09C);
    release_mov();
    start_req(1'b1, 3'b001, 32'h0000_0012, 32'h0);
    wait_moc(-1, 1'b0, lat);
    check("hr_zext", DATA_OUT, 32'h0000802C);
    release_mov();

    // Misaligned word read (reserved size code): reads aligned base, flags error.
    start_req(1'b1, 3'b011, 32'hABCD_0013, 32'h0);
    wait_moc(-1, 1'b0, lat);
    check("mw_data",  DATA_OUT,           32'hE09C802C);
    check("mw_align", {31'd0, ALIGN_ERR}, 32'd1);
    release_mov();

    // Byte reads, signed vs unsigned.
    start_req(1'b1, 3'b100, 32'h0000_0022, 32'h0);
    wait_moc(-1, 1'b0, lat);
    check("br_s_lat",  lat,      32'd3);
    check("br_s_data", DATA_OUT, 32'hFFFFFF80);
    release_mov();
    start_req(1'b1, 3'b000, 32'h0000_0022, 32'h0);
    wait_moc(-1, 1'b0, lat);
    check("br_u_lat",  lat,      32'd3);
    check("br_u_data", DATA_OUT, 32'h00000080);

    // MOC handshake: MOV held for 5 edges, then dropped.
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); @(negedge CLK);
      check("hs_hold", {31'd0, MOC}, 32'd1);
    end
    release_mov();
    check("hs_no_accept", {31'd0, MEM_EN}, 32'd0);

    // Halfword write to odd address.
    start_req(1'b0, 3'b001, 32'h0000_0041, 32'h1234ABCD);
    wait_moc(-1, 1'b0, lat);
    check("hw_lat",   lat,                 32'd5);
    check("hw_align", {31'd0, ALIGN_ERR},  32'd1);
    check("hw_dout",  DATA_OUT,            32'h00000080);
    check("hw_ram40", {24'd0, ram[8'h40]}, 32'hAB);
    check("hw_ram41", {24'd0, ram[8'h41]}, 32'hCD);
    check("hw_ram42", {24'd0, ram[8'h42]}, 32'h77);
    release_mov();

    // Reset during beat 2 of a word write.
    start_req(1'b0, 3'b010, 32'h0000_0060, 32'hAABBCCDD);
    @(posedge CLK);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("rw_beat2_addr", {24'd0, MEM_ADDR},  32'h62);
    check("rw_beat2_data", {24'd0, MEM_WDATA}, 32'hCC);
    RST_N = 1'b0;
    #1;
    check("rw_rst_en",    {31'd0, MEM_EN},    32'd0);
    check("rw_rst_we",    {31'd0, MEM_WE},    32'd0);
    check("rw_rst_addr",  {24'd0, MEM_ADDR},  32'd0);
    check("rw_rst_wdata", {24'd0, MEM_WDATA}, 32'd0);
    check("rw_rst_dout",  DATA_OUT,           32'd0);
    check("rw_rst_moc",   {31'd0, MOC},       32'd0);
    MOV = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("rw_ram60", {24'd0, ram[8'h60]}, 32'hAA);
    check("rw_ram61", {24'd0, ram[8'h61]}, 32'hBB);
    check("rw_ram62", {24'd0, ram[8'h62]}, 32'h11);
    check("rw_ram63", {24'd0, ram[8'h63]}, 32'h11);
    start_req(1'b1, 3'b000, 32'h0000_0061, 32'h0);
    wait_moc(-1, 1'b0, lat);
    check("rw_after_lat",  lat,      32'd3);
    check("rw_after_data", DATA_OUT, 32'h000000BB);
    release_mov();

    // MOV drops during beat 1 of a word read.
    start_req(1'b1, 3'b010, 32'h0000_0010, 32'h0);
    wait_moc(2, 1'b0, lat);
    check("gl_lat",  lat,      32'd9);
    check("gl_data", DATA_OUT, 32'hE09C802C);
    @(posedge CLK); @(negedge CLK);
    check("gl_pulse", {31'd0, MOC}, 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("gl_idle_en",  {31'd0, MEM_EN}, 32'd0);
    check("gl_idle_moc", {31'd0, MOC},    32'd0);
    start_req(1'b1, 3'b100, 32'h0000_0022, 32'h0);
    wait_moc(-1, 1'b0, lat);
    check("gl_next_lat",  lat,      32'd3);
    check("gl_next_data", DATA_OUT, 32'hFFFFFF80);
    release_mov();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
